// File: rtl/hough_accum_sched_pkg.sv
// Shared constants and state encoding for the Hough accumulator buffer sequencer.
package hough_accum_sched_pkg;

    localparam int RHOS             = 1469;
    localparam int RHO_RANGE        = 2 * RHOS;
    localparam int THETAS           = 180;
    localparam int THETA_UNROLL     = 4;
    localparam int VOTE_PIPE_LAT    = 3;
    localparam int ACCUM_BUFF_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        VOTE,
        DRAIN,
        SCAN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/hough_accum_sched_scan_addr_gen.sv
// Rho/theta-group walker producing linear accumulator addresses; with bubbles_en
// set it inserts one idle slot after each rho row (scan), otherwise it runs gap-free (clear).
module hough_scan_addr_gen #(
    parameter int RHO_RANGE    = 4,
    parameter int THETAS       = 8,
    parameter int THETA_UNROLL = 4,
    parameter int ADDR_W       = 3,
    parameter int RHO_W        = 2,
    parameter int THETA_W      = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               bubbles_en,
    output logic [ADDR_W-1:0]  addr,
    output logic [RHO_W-1:0]   rho,
    output logic [THETA_W-1:0] theta,
    output logic               bubble,
    output logic               last
);

    localparam int GROUPS = THETAS / THETA_UNROLL;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RHO_W-1:0]  rho_q, rho_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic              bubble_q, bubble_d;
    logic              row_end, last_row;

    always_comb begin
        row_end  = (grp_q == GRP_W'(GROUPS - 1));
        last_row = (rho_q == RHO_W'(RHO_RANGE - 1));
        last     = bubbles_en ? (bubble_q && last_row) : (row_end && last_row && !bubble_q);

        addr_d   = addr_q;
        rho_d    = rho_q;
        grp_d    = grp_q;
        bubble_d = bubble_q;

        if (en) begin
            // Terminal position returns everything to zero so the next phase starts clean.
            if (last) begin
                addr_d   = '0;
                rho_d    = '0;
                grp_d    = '0;
                bubble_d = 1'b0;
            end else if (bubble_q) begin
                bubble_d = 1'b0;
                rho_d    = rho_q + 1'b1;
            end else if (row_end) begin
                grp_d  = '0;
                addr_d = addr_q + 1'b1;
                if (bubbles_en) begin
                    bubble_d = 1'b1;
                end else begin
                    rho_d = rho_q + 1'b1;
                end
            end else begin
                grp_d  = grp_q + 1'b1;
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q   <= '0;
            rho_q    <= '0;
            grp_q    <= '0;
            bubble_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            rho_q    <= rho_d;
            grp_q    <= grp_d;
            bubble_q <= bubble_d;
        end
    end

    assign addr   = addr_q;
    assign rho    = rho_q;
    assign theta  = THETA_W'(int'(grp_q) * THETA_UNROLL);
    assign bubble = bubble_q;

endmodule

// File: rtl/hough_accum_sched.sv
// Frame sequencer and BRAM port arbiter for the Hough accumulator (CLEAR/VOTE/DRAIN/SCAN).
// Optional clear phase is compiled in with macro ACCUM_CLEAR_EN; VOTE_PIPE_LAT must be >= 1.
module hough_accum_sched
    import hough_accum_sched_pkg::*;
#(
    parameter int RHO_RANGE     = hough_accum_sched_pkg::RHO_RANGE,
    parameter int THETAS        = hough_accum_sched_pkg::THETAS,
    parameter int THETA_UNROLL  = hough_accum_sched_pkg::THETA_UNROLL,
    parameter int VOTE_PIPE_LAT = hough_accum_sched_pkg::VOTE_PIPE_LAT,
    parameter int ADDR_W        = $clog2(RHO_RANGE * THETAS / THETA_UNROLL)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        vote_req,
    input  logic [ADDR_W-1:0]           vote_addr,
    input  logic [THETA_UNROLL-1:0]     vote_we,
    input  logic                        vote_last,
    output logic                        vote_grant,
    output logic [ADDR_W-1:0]           bram_addr,
    output logic [THETA_UNROLL-1:0]     bram_we,
    output logic                        bram_clr,
    output logic                        scan_valid,
    output logic [$clog2(RHO_RANGE)-1:0] scan_rho,
    output logic [$clog2(THETAS)-1:0]   scan_theta,
    output logic                        busy,
    output logic                        accum_buff_done
);

    localparam int RHO_W   = $clog2(RHO_RANGE);
    localparam int THETA_W = $clog2(THETAS);
    localparam int DRAIN_W = $clog2(VOTE_PIPE_LAT + 1);

    sched_state_t       state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic               gen_en, gen_bubbles, gen_bubble, gen_last;
    logic [ADDR_W-1:0]  gen_addr;
    logic [RHO_W-1:0]   gen_rho;
    logic [THETA_W-1:0] gen_theta;

    assign gen_en      = (state_q == CLEAR) || (state_q == SCAN);
    assign gen_bubbles = (state_q == SCAN);

    hough_scan_addr_gen #(
        .RHO_RANGE   (RHO_RANGE),
        .THETAS      (THETAS),
        .THETA_UNROLL(THETA_UNROLL),
        .ADDR_W      (ADDR_W),
        .RHO_W       (RHO_W),
        .THETA_W     (THETA_W)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .en        (gen_en),
        .bubbles_en(gen_bubbles),
        .addr      (gen_addr),
        .rho       (gen_rho),
        .theta     (gen_theta),
        .bubble    (gen_bubble),
        .last      (gen_last)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
`ifdef ACCUM_CLEAR_EN
                    state_d = CLEAR;
`else
                    state_d = VOTE;
`endif
                end
            end
            CLEAR: if (gen_last) state_d = VOTE;
            VOTE: begin
                if (vote_last) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(VOTE_PIPE_LAT - 1)) begin
                    state_d = SCAN;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            SCAN:    if (gen_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Port mux: every output decodes from the registered state, so IDLE drives all zeros.
    always_comb begin
        vote_grant      = 1'b0;
        bram_addr       = '0;
        bram_we         = '0;
        bram_clr        = 1'b0;
        scan_valid      = 1'b0;
        scan_rho        = '0;
        scan_theta      = '0;
        busy            = (state_q != IDLE);
        accum_buff_done = (state_q == DONE);
        unique case (state_q)
            CLEAR: begin
                bram_addr = gen_addr;
                bram_we   = '1;
`ifdef ACCUM_CLEAR_EN
                bram_clr  = 1'b1;
`endif
            end
            VOTE: begin
                vote_grant = 1'b1;
                bram_addr  = vote_addr;
                bram_we    = vote_req ? vote_we : '0;
            end
            SCAN: begin
                bram_addr  = gen_addr;
                scan_valid = !gen_bubble;
                scan_rho   = gen_rho;
                scan_theta = gen_theta;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

endmodule

// File: tb/tb_hough_accum_sched.sv
// Directed/randomized frame bench for hough_accum_sched with small geometry (4 rho x 8 theta).
module tb_hough_accum_sched;

    localparam int RR  = 4;
    localparam int TH  = 8;
    localparam int TU  = 4;
    localparam int LAT = 3;
    localparam int G   = TH / TU;
    localparam int N   = RR * G;
    localparam int AW  = $clog2(N);
    localparam int RW  = $clog2(RR);
    localparam int TW  = $clog2(TH);

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          vote_req;
    logic [AW-1:0] vote_addr;
    logic [TU-1:0] vote_we;
    logic          vote_last;
    logic          vote_grant;
    logic [AW-1:0] bram_addr;
    logic [TU-1:0] bram_we;
    logic          bram_clr;
    logic          scan_valid;
    logic [RW-1:0] scan_rho;
    logic [TW-1:0] scan_theta;
    logic          busy;
    logic          accum_buff_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit v;
        int rho;
        int theta;
        int addr;
    } scan_t;
    scan_t exp_q[$];

    hough_accum_sched #(
        .RHO_RANGE    (RR),
        .THETAS       (TH),
        .THETA_UNROLL (TU),
        .VOTE_PIPE_LAT(LAT),
        .ADDR_W       (AW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .vote_req       (vote_req),
        .vote_addr      (vote_addr),
        .vote_we        (vote_we),
        .vote_last      (vote_last),
        .vote_grant     (vote_grant),
        .bram_addr      (bram_addr),
        .bram_we        (bram_we),
        .bram_clr       (bram_clr),
        .scan_valid     (scan_valid),
        .scan_rho       (scan_rho),
        .scan_theta     (scan_theta),
        .busy           (busy),
        .accum_buff_done(accum_buff_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_vote();
        vote_req  = 1'($urandom_range(0, 1));
        vote_addr = AW'($urandom_range(0, N - 1));
        vote_we   = TU'($urandom);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant"}, 32'(vote_grant), 32'd0);
        chk({tag, "_we"}, 32'(bram_we), 32'd0);
        chk({tag, "_clr"}, 32'(bram_clr), 32'd0);
        chk({tag, "_sv"}, 32'(scan_valid), 32'd0);
        chk({tag, "_done"}, 32'(accum_buff_done), 32'd0);
        chk({tag, "_addr"}, 32'(bram_addr), 32'd0);
    endtask

    task automatic run_frame(input bit abort);
        int nv;
        int abort_idx;
        abort_idx = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (abort_idx < 0 && exp_q[k].v && exp_q[k].rho == 2) abort_idx = k;
        end

        rand_vote();
        start = 1'b1;
        #1;
        chk_idle("pre_start");
        tick();
        start = 1'b0;

`ifdef ACCUM_CLEAR_EN
        for (int i = 0; i < N; i++) begin
            rand_vote();
            vote_req = 1'b1;
            start    = (i == 3);
            #1;
            chk("clr_flag", 32'(bram_clr), 32'd1);
            chk("clr_we", 32'(bram_we), 32'(TU'('1)));
            chk("clr_addr", 32'(bram_addr), 32'(i));
            chk("clr_grant", 32'(vote_grant), 32'd0);
            chk("clr_busy", 32'(busy), 32'd1);
            tick();
        end
        start = 1'b0;
`endif

        vote_req  = 1'b1;
        vote_addr = AW'(5);
        vote_we   = 4'b0010;
        #1;
        chk("vote_first_grant", 32'(vote_grant), 32'd1);
        chk("vote_first_clr", 32'(bram_clr), 32'd0);
        chk("vote_fixed_addr", 32'(bram_addr), 32'd5);
        chk("vote_fixed_we", 32'(bram_we), 32'b0010);
        tick();

        nv = $urandom_range(3, 8);
        for (int i = 0; i < nv; i++) begin
            rand_vote();
            start = (i == 1);
            #1;
            chk("vote_grant", 32'(vote_grant), 32'd1);
            chk("vote_addr", 32'(bram_addr), 32'(vote_addr));
            chk("vote_we", 32'(bram_we), vote_req ? 32'(vote_we) : 32'd0);
            tick();
        end
        start = 1'b0;

        vote_req  = 1'b1;
        vote_addr = AW'(2);
        vote_we   = TU'($urandom_range(1, 15));
        vote_last = 1'b1;
        #1;
        chk("last_addr", 32'(bram_addr), 32'd2);
        chk("last_we", 32'(bram_we), 32'(vote_we));
        tick();
        vote_last = 1'b0;

        for (int d = 0; d < LAT; d++) begin
            rand_vote();
            #1;
            chk("drain_we", 32'(bram_we), 32'd0);
            chk("drain_grant", 32'(vote_grant), 32'd0);
            chk("drain_sv", 32'(scan_valid), 32'd0);
            chk("drain_busy", 32'(busy), 32'd1);
            tick();
        end

        for (int k = 0; k < exp_q.size(); k++) begin
            rand_vote();
            #1;
            chk("scan_valid", 32'(scan_valid), 32'(exp_q[k].v));
            chk("scan_we", 32'(bram_we), 32'd0);
            chk("scan_done", 32'(accum_buff_done), 32'd0);
            if (exp_q[k].v) begin
                chk("scan_rho", 32'(scan_rho), 32'(exp_q[k].rho));
                chk("scan_theta", 32'(scan_theta), 32'(exp_q[k].theta));
                chk("scan_addr", 32'(bram_addr), 32'(exp_q[k].addr));
            end
            if (abort && k == abort_idx) begin
                reset = 1'b1;
                tick();
                chk_idle("abort");
                reset = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    chk("abort_no_done", 32'(accum_buff_done), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                end
                return;
            end
            tick();
        end

        vote_req = 1'b0;
        #1;
        chk("done_pulse", 32'(accum_buff_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        tick();
        chk_idle("post_done");
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        vote_req  = 1'b0;
        vote_addr = '0;
        vote_we   = '0;
        vote_last = 1'b0;

        for (int r = 0; r < RR; r++) begin
            for (int t = 0; t < TH; t += TU) begin
                exp_q.push_back('{v: 1'b1, rho: r, theta: t, addr: r * G + t / TU});
            end
            exp_q.push_back('{v: 1'b0, rho: 0, theta: 0, addr: 0});
        end

        tick();
        tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();
        chk_idle("idle");

        run_frame(1'b0);
        tick();
        run_frame(1'b1);
        tick();
        run_frame(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
